// File: rtl/seg_capture.sv
// Captures four multiplexed seven-segment digits from a display driver's an/seg lines.
// A digit is taken only after an/seg are steady for SETTLE_CYCLES; all four are published together.
module seg_capture #(
  parameter int SETTLE_CYCLES = 16,
  parameter int DEAD_CYCLES   = 2_000_000
) (
  input  logic        Clk100M,
  input  logic        reset,
  input  logic [7:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  glyph_ok,
  output logic        frame_done,
  output logic        dead,
  output logic        multi_an_err
);

  localparam logic [7:0]  L_SETTLE = 8'(SETTLE_CYCLES);
  localparam logic [23:0] L_DEAD   = 24'(DEAD_CYCLES);

  typedef enum logic [1:0] {ST_WAIT, ST_SETTLE, ST_HELD} state_t;

  logic [3:0]  r_an_s1, r_an_s2, r_an_prev;
  logic [7:0]  r_seg_s1, r_seg_s2, r_seg_prev;
  state_t      r_state, w_state_next;
  logic [7:0]  r_stable, w_stable_next;
  logic [3:0]  r_seen;
  logic [23:0] r_dead_cnt;
  logic [15:0] r_digits;
  logic [3:0]  r_dp, r_ok;
  logic        r_frame_done, r_multi_err;

  logic [3:0]  w_an, w_low;
  logic [7:0]  w_seg;
  logic [6:0]  w_pat;
  logic [3:0]  w_nib;
  logic        w_ok;
  logic        w_changed, w_single, w_multi, w_blank, w_sample, w_frame;
  logic [15:0] w_sh_digits;
  logic [3:0]  w_sh_dp, w_sh_ok;

  // Synchronizer idles at all-ones so reset looks like a blanked display.
  always_ff @(posedge Clk100M or posedge reset) begin
    if (reset) begin
      r_an_s1    <= 4'hF;
      r_an_s2    <= 4'hF;
      r_an_prev  <= 4'hF;
      r_seg_s1   <= 8'hFF;
      r_seg_s2   <= 8'hFF;
      r_seg_prev <= 8'hFF;
    end else begin
      r_an_s1    <= an;
      r_an_s2    <= r_an_s1;
      r_an_prev  <= r_an_s2;
      r_seg_s1   <= seg;
      r_seg_s2   <= r_seg_s1;
      r_seg_prev <= r_seg_s2;
    end
  end

  assign w_an      = r_an_s2;
  assign w_seg     = r_seg_s2;
  assign w_low     = ~w_an;
  assign w_changed = (w_an != r_an_prev) || (w_seg != r_seg_prev);
  assign w_blank   = (w_low == 4'h0);
  assign w_single  = !w_blank && ((w_low & 4'(w_low - 4'd1)) == 4'h0);
  assign w_multi   = !w_blank && !w_single;
  assign w_pat     = ~w_seg[6:0];

  always_comb begin
    w_nib = 4'h0;
    w_ok  = 1'b1;
    case (w_pat)
      7'h3F: w_nib = 4'h0;
      7'h06: w_nib = 4'h1;
      7'h5B: w_nib = 4'h2;
      7'h4F: w_nib = 4'h3;
      7'h66: w_nib = 4'h4;
      7'h6D: w_nib = 4'h5;
      7'h7D: w_nib = 4'h6;
      7'h07: w_nib = 4'h7;
      7'h7F: w_nib = 4'h8;
      7'h6F: w_nib = 4'h9;
      7'h77: w_nib = 4'hA;
      7'h7C: w_nib = 4'hB;
      7'h39: w_nib = 4'hC;
      7'h5E: w_nib = 4'hD;
      7'h79: w_nib = 4'hE;
      7'h71: w_nib = 4'hF;
      default: w_ok = 1'b0;
    endcase
  end

  always_ff @(posedge Clk100M or posedge reset) begin
    if (reset) begin
      r_state  <= ST_WAIT;
      r_stable <= 8'd0;
    end else begin
      r_state  <= w_state_next;
      r_stable <= w_stable_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_stable_next = r_stable;
    w_sample      = 1'b0;
    if (w_multi || w_blank) begin
      w_state_next  = ST_WAIT;
      w_stable_next = 8'd0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          w_state_next  = ST_SETTLE;
          w_stable_next = 8'd1;
        end
        ST_SETTLE: begin
          if (w_changed) begin
            w_stable_next = 8'd1;
          end else if (r_stable >= L_SETTLE - 8'd1) begin
            // This cycle is the SETTLE_CYCLES-th steady one: take the digit.
            w_sample      = 1'b1;
            w_state_next  = ST_HELD;
            w_stable_next = L_SETTLE;
          end else begin
            w_stable_next = r_stable + 8'd1;
          end
        end
        ST_HELD: begin
          if (w_changed) begin
            w_state_next  = ST_SETTLE;
            w_stable_next = 8'd1;
          end
        end
        default: begin
          w_state_next  = ST_WAIT;
          w_stable_next = 8'd0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      logic [3:0] r_nib;
      logic       r_sdp;
      logic       r_sok;
      always_ff @(posedge Clk100M or posedge reset) begin
        if (reset) begin
          r_nib <= 4'h0;
          r_sdp <= 1'b0;
          r_sok <= 1'b0;
        end else if (w_sample && w_low[gi]) begin
          r_nib <= w_nib;
          r_sdp <= ~w_seg[7];
          r_sok <= w_ok;
        end
      end
      assign w_sh_digits[4*gi +: 4] = r_nib;
      assign w_sh_dp[gi]            = r_sdp;
      assign w_sh_ok[gi]            = r_sok;
    end
  endgenerate

  assign w_frame = (r_seen == 4'hF);

  always_ff @(posedge Clk100M or posedge reset) begin
    if (reset) begin
      r_seen       <= 4'h0;
      r_digits     <= 16'h0000;
      r_dp         <= 4'h0;
      r_ok         <= 4'h0;
      r_frame_done <= 1'b0;
      r_multi_err  <= 1'b0;
      r_dead_cnt   <= 24'd0;
    end else begin
      r_frame_done <= w_frame;
      if (w_frame) begin
        r_seen   <= 4'h0;
        r_digits <= w_sh_digits;
        r_dp     <= w_sh_dp;
        r_ok     <= w_sh_ok;
      end else if (w_sample) begin
        r_seen <= r_seen | w_low;
      end
      if (w_multi) begin
        r_multi_err <= 1'b1;
      end
      if (w_sample) begin
        r_dead_cnt <= 24'd0;
      end else if (r_dead_cnt != L_DEAD) begin
        r_dead_cnt <= r_dead_cnt + 24'd1;
      end
    end
  end

  assign digits       = r_digits;
  assign dp           = r_dp;
  assign glyph_ok     = r_ok;
  assign frame_done   = r_frame_done;
  assign multi_an_err = r_multi_err;
  assign dead         = (r_dead_cnt == L_DEAD);

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture: scans, settle boundary, blank/dp, multi-anode, reset and dead detection.
`timescale 1ns/1ps
module tb_seg_capture;

  logic        Clk100M = 1'b0;
  logic        reset   = 1'b1;
  logic [7:0]  seg     = 8'hFF;
  logic [3:0]  an      = 4'hF;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  glyph_ok;
  logic        frame_done;
  logic        dead;
  logic        multi_an_err;

  int n_checks = 0;
  int n_errors = 0;
  int frame_cnt = 0;

  seg_capture #(.SETTLE_CYCLES(16), .DEAD_CYCLES(100)) dut (
    .Clk100M     (Clk100M),
    .reset       (reset),
    .seg         (seg),
    .an          (an),
    .digits      (digits),
    .dp          (dp),
    .glyph_ok    (glyph_ok),
    .frame_done  (frame_done),
    .dead        (dead),
    .multi_an_err(multi_an_err)
  );

  always #5 Clk100M = ~Clk100M;

  // Counts cycles during which frame_done is high.
  always @(posedge Clk100M) begin
    if (frame_done === 1'b1) frame_cnt <= frame_cnt + 1;
  end

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'h3F; 4'h1: glyph = 7'h06; 4'h2: glyph = 7'h5B; 4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66; 4'h5: glyph = 7'h6D; 4'h6: glyph = 7'h7D; 4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F; 4'h9: glyph = 7'h6F; 4'hA: glyph = 7'h77; 4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39; 4'hD: glyph = 7'h5E; 4'hE: glyph = 7'h79; default: glyph = 7'h71;
    endcase
  endfunction

  task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge Clk100M);
  endtask

  task automatic show(input int pos, input logic [3:0] nib, input int n);
    logic [3:0] a;
    a = ~(4'b0001 << pos);
    drive(a, {1'b1, ~glyph(nib)}, n);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(4'hF, 8'hFF, 4);
    n_checks += 6;
    if (digits !== 16'h0000) begin n_errors++; $display("FAIL reset_digits actual=%h required=0000", digits); end
    if (dp !== 4'h0) begin n_errors++; $display("FAIL reset_dp actual=%b required=0000", dp); end
    if (glyph_ok !== 4'h0) begin n_errors++; $display("FAIL reset_glyph actual=%b required=0000", glyph_ok); end
    if (frame_done !== 1'b0) begin n_errors++; $display("FAIL reset_frame_done actual=%b required=0", frame_done); end
    if (dead !== 1'b0) begin n_errors++; $display("FAIL reset_dead actual=%b required=0", dead); end
    if (multi_an_err !== 1'b0) begin n_errors++; $display("FAIL reset_multi actual=%b required=0", multi_an_err); end
    $display("test_reset: digits=%h dp=%b glyph_ok=%b", digits, dp, glyph_ok);
    reset = 1'b0;
    drive(4'hF, 8'hFF, 2);
  endtask

  task automatic test_scan_1234;
    int f0;
    f0 = frame_cnt;
    show(3, 4'h1, 64);
    show(2, 4'h2, 64);
    show(1, 4'h3, 64);
    n_checks += 2;
    if (digits !== 16'h0000) begin n_errors++; $display("FAIL scan_partial_digits actual=%h required=0000", digits); end
    if (frame_cnt != f0) begin n_errors++; $display("FAIL scan_partial_frames actual=%0d required=0", frame_cnt - f0); end
    show(0, 4'h4, 64);
    drive(4'hF, 8'hFF, 10);
    n_checks += 4;
    if (frame_cnt - f0 != 1) begin n_errors++; $display("FAIL scan_frames actual=%0d required=1", frame_cnt - f0); end
    if (digits !== 16'h1234) begin n_errors++; $display("FAIL scan_digits actual=%h required=1234", digits); end
    if (glyph_ok !== 4'hF) begin n_errors++; $display("FAIL scan_glyph actual=%b required=1111", glyph_ok); end
    if (dp !== 4'h0) begin n_errors++; $display("FAIL scan_dp actual=%b required=0000", dp); end
    $display("test_scan_1234: digits=%h glyph_ok=%b dp=%b frames=%0d", digits, glyph_ok, dp, frame_cnt - f0);
  endtask

  task automatic test_settle_boundary;
    int f0;
    f0 = frame_cnt;
    for (int r = 0; r < 2; r++) begin
      show(3, 4'h5, 15);
      show(2, 4'h6, 15);
      show(1, 4'h7, 15);
      show(0, 4'h8, 15);
    end
    drive(4'hF, 8'hFF, 10);
    n_checks += 2;
    if (frame_cnt != f0) begin n_errors++; $display("FAIL short_frames actual=%0d required=0", frame_cnt - f0); end
    if (digits !== 16'h1234) begin n_errors++; $display("FAIL short_digits actual=%h required=1234", digits); end
    $display("test_settle_boundary 15: digits=%h frames=%0d", digits, frame_cnt - f0);
    show(3, 4'h5, 16);
    show(2, 4'h6, 16);
    show(1, 4'h7, 16);
    show(0, 4'h8, 16);
    drive(4'hF, 8'hFF, 10);
    n_checks += 2;
    if (frame_cnt - f0 != 1) begin n_errors++; $display("FAIL exact_frames actual=%0d required=1", frame_cnt - f0); end
    if (digits !== 16'h5678) begin n_errors++; $display("FAIL exact_digits actual=%h required=5678", digits); end
    $display("test_settle_boundary 16: digits=%h frames=%0d", digits, frame_cnt - f0);
  endtask

  task automatic test_blank_dp;
    int f0;
    f0 = frame_cnt;
    show(3, 4'h9, 64);
    drive(4'b1011, 8'h7F, 64);
    show(1, 4'hA, 64);
    show(0, 4'hB, 64);
    drive(4'hF, 8'hFF, 10);
    n_checks += 4;
    if (frame_cnt - f0 != 1) begin n_errors++; $display("FAIL blank_frames actual=%0d required=1", frame_cnt - f0); end
    if (digits !== 16'h90AB) begin n_errors++; $display("FAIL blank_digits actual=%h required=90ab", digits); end
    if (glyph_ok !== 4'b1011) begin n_errors++; $display("FAIL blank_glyph actual=%b required=1011", glyph_ok); end
    if (dp !== 4'b0100) begin n_errors++; $display("FAIL blank_dp actual=%b required=0100", dp); end
    $display("test_blank_dp: digits=%h glyph_ok=%b dp=%b", digits, glyph_ok, dp);
  endtask

  task automatic test_multi_anode;
    int f0;
    f0 = frame_cnt;
    n_checks += 1;
    if (multi_an_err !== 1'b0) begin n_errors++; $display("FAIL multi_before actual=%b required=0", multi_an_err); end
    show(3, 4'hC, 64);
    show(2, 4'hD, 64);
    show(1, 4'hE, 10);
    drive(4'b0011, {1'b1, ~glyph(4'hE)}, 1);
    show(1, 4'hE, 10);
    show(0, 4'hF, 64);
    drive(4'hF, 8'hFF, 10);
    n_checks += 3;
    if (multi_an_err !== 1'b1) begin n_errors++; $display("FAIL multi_set actual=%b required=1", multi_an_err); end
    if (frame_cnt != f0) begin n_errors++; $display("FAIL multi_early_frame actual=%0d required=0", frame_cnt - f0); end
    if (digits !== 16'h90AB) begin n_errors++; $display("FAIL multi_hold_digits actual=%h required=90ab", digits); end
    show(1, 4'hE, 64);
    drive(4'hF, 8'hFF, 10);
    n_checks += 3;
    if (frame_cnt - f0 != 1) begin n_errors++; $display("FAIL multi_frames actual=%0d required=1", frame_cnt - f0); end
    if (digits !== 16'hCDEF) begin n_errors++; $display("FAIL multi_digits actual=%h required=cdef", digits); end
    if (multi_an_err !== 1'b1) begin n_errors++; $display("FAIL multi_sticky actual=%b required=1", multi_an_err); end
    $display("test_multi_anode: digits=%h multi_an_err=%b frames=%0d", digits, multi_an_err, frame_cnt - f0);
  endtask

  task automatic test_reset_mid_frame;
    int f0;
    show(3, 4'h1, 64);
    show(2, 4'h2, 64);
    show(1, 4'h3, 64);
    f0 = frame_cnt;
    reset = 1'b1;
    drive(4'hF, 8'hFF, 3);
    reset = 1'b0;
    n_checks += 3;
    if (digits !== 16'h0000) begin n_errors++; $display("FAIL rmid_digits actual=%h required=0000", digits); end
    if (glyph_ok !== 4'h0) begin n_errors++; $display("FAIL rmid_glyph actual=%b required=0000", glyph_ok); end
    if (multi_an_err !== 1'b0) begin n_errors++; $display("FAIL rmid_multi actual=%b required=0", multi_an_err); end
    drive(4'hF, 8'hFF, 2);
    show(0, 4'h4, 64);
    drive(4'hF, 8'hFF, 10);
    n_checks += 1;
    if (frame_cnt != f0) begin n_errors++; $display("FAIL rmid_stale_frame actual=%0d required=0", frame_cnt - f0); end
    show(3, 4'h7, 64);
    show(2, 4'h8, 64);
    show(1, 4'h9, 64);
    drive(4'hF, 8'hFF, 10);
    n_checks += 2;
    if (frame_cnt - f0 != 1) begin n_errors++; $display("FAIL rmid_frames actual=%0d required=1", frame_cnt - f0); end
    if (digits !== 16'h7894) begin n_errors++; $display("FAIL rmid_new_digits actual=%h required=7894", digits); end
    $display("test_reset_mid_frame: digits=%h frames=%0d", digits, frame_cnt - f0);
  endtask

  task automatic test_dead;
    reset = 1'b1;
    drive(4'hF, 8'hFF, 2);
    reset = 1'b0;
    drive(4'hF, 8'hFF, 90);
    n_checks += 1;
    if (dead !== 1'b0) begin n_errors++; $display("FAIL dead_early actual=%b required=0", dead); end
    drive(4'hF, 8'hFF, 20);
    n_checks += 1;
    if (dead !== 1'b1) begin n_errors++; $display("FAIL dead_set actual=%b required=1", dead); end
    drive(4'hF, 8'hFF, 200);
    n_checks += 1;
    if (dead !== 1'b1) begin n_errors++; $display("FAIL dead_saturate actual=%b required=1", dead); end
    show(2, 4'h3, 10);
    n_checks += 1;
    if (dead !== 1'b1) begin n_errors++; $display("FAIL dead_before_sample actual=%b required=1", dead); end
    show(2, 4'h3, 20);
    n_checks += 2;
    if (dead !== 1'b0) begin n_errors++; $display("FAIL dead_clear actual=%b required=0", dead); end
    if (digits !== 16'h0000) begin n_errors++; $display("FAIL dead_digits actual=%h required=0000", digits); end
    $display("test_dead: dead=%b digits=%h", dead, digits);
  endtask

  initial begin
    @(negedge Clk100M);
    test_reset();
    test_scan_1234();
    test_settle_boundary();
    test_blank_dp();
    test_multi_anode();
    test_reset_mid_frame();
    test_dead();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
